// File: rtl/tpm_request_queue.sv
// tpm_request_queue
// Three independent request FIFOs feeding the ports of the triple-ported
// memory. Each client pushes {addr, data, wen} over valid/ready; the memory
// side sees the FIFO head, which only advances when freeze_inputs is low.
// Every output is decoded from registered state; no input reaches an output
// combinationally.
module tpm_request_queue #(
  parameter int DEPTH = 4,
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          port1_req_valid,
  output logic          port1_req_ready,
  input  logic [11:0]   port1_req_addr,
  input  logic [15:0]   port1_req_data,
  input  logic          port1_req_wen,
  input  logic          port2_req_valid,
  output logic          port2_req_ready,
  input  logic [11:0]   port2_req_addr,
  input  logic [15:0]   port2_req_data,
  input  logic          port2_req_wen,
  input  logic          port3_req_valid,
  output logic          port3_req_ready,
  input  logic [11:0]   port3_req_addr,
  input  logic [15:0]   port3_req_data,
  input  logic          port3_req_wen,
  output logic [11:0]   port1_addr,
  output logic [15:0]   port1_data_in,
  output logic          port1_wen,
  output logic          port1_valid_in,
  output logic [11:0]   port2_addr,
  output logic [15:0]   port2_data_in,
  output logic          port2_wen,
  output logic          port2_valid_in,
  output logic [11:0]   port3_addr,
  output logic [15:0]   port3_data_in,
  output logic          port3_wen,
  output logic          port3_valid_in,
  input  logic          freeze_inputs,
  output logic [CW-1:0] port1_count,
  output logic [CW-1:0] port2_count,
  output logic [CW-1:0] port3_count,
  output logic          idle
);

  localparam int AW = $clog2(DEPTH);

  // Entry layout: addr in [28:17], data in [16:1], wen in [0].
  logic [2:0]    req_valid_s;
  logic [11:0]   req_addr_s  [3];
  logic [15:0]   req_data_s  [3];
  logic [2:0]    req_wen_s;
  logic [2:0]    notfull_s;
  logic [2:0]    nonempty_s;
  logic [28:0]   head_s      [3];
  logic [CW-1:0] count_s     [3];

  assign req_valid_s   = {port3_req_valid, port2_req_valid, port1_req_valid};
  assign req_wen_s     = {port3_req_wen, port2_req_wen, port1_req_wen};
  assign req_addr_s[0] = port1_req_addr;
  assign req_addr_s[1] = port2_req_addr;
  assign req_addr_s[2] = port3_req_addr;
  assign req_data_s[0] = port1_req_data;
  assign req_data_s[1] = port2_req_data;
  assign req_data_s[2] = port3_req_data;

  for (genvar g = 0; g < 3; g++) begin : g_fifo
    logic [28:0]   mem_r [DEPTH];
    logic [AW-1:0] wr_ptr_r;
    logic [AW-1:0] rd_ptr_r;
    logic [CW-1:0] count_r;
    logic          push_s;
    logic          pop_s;

    // Full/empty come from the counter alone; pointers simply wrap mod DEPTH.
    assign notfull_s[g]  = (count_r != CW'(DEPTH));
    assign nonempty_s[g] = (count_r != CW'(0));
    assign push_s        = req_valid_s[g] & notfull_s[g];
    assign pop_s         = nonempty_s[g] & ~freeze_inputs;
    assign count_s[g]    = count_r;

    // Entry storage; contents are don't-care after reset, so no reset here.
    always_ff @(posedge clk) begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {req_addr_s[g], req_data_s[g], req_wen_s[g]};
      end
    end

    // Pointer and occupancy update; reset discards all queued entries.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        wr_ptr_r <= AW'(0);
        rd_ptr_r <= AW'(0);
        count_r  <= CW'(0);
      end else begin
        if (push_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (pop_s) begin
          rd_ptr_r <= rd_ptr_r + AW'(1);
        end
        case ({push_s, pop_s})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
    end

    // Head presented to memory; forced to zero when the FIFO is empty.
    always_comb begin
      head_s[g] = 29'd0;
      if (nonempty_s[g]) begin
        head_s[g] = mem_r[rd_ptr_r];
      end else begin
        head_s[g] = 29'd0;
      end
    end
  end

  assign port1_req_ready = notfull_s[0];
  assign port2_req_ready = notfull_s[1];
  assign port3_req_ready = notfull_s[2];

  assign port1_valid_in = nonempty_s[0];
  assign port2_valid_in = nonempty_s[1];
  assign port3_valid_in = nonempty_s[2];

  assign port1_addr    = head_s[0][28:17];
  assign port1_data_in = head_s[0][16:1];
  assign port1_wen     = head_s[0][0];
  assign port2_addr    = head_s[1][28:17];
  assign port2_data_in = head_s[1][16:1];
  assign port2_wen     = head_s[1][0];
  assign port3_addr    = head_s[2][28:17];
  assign port3_data_in = head_s[2][16:1];
  assign port3_wen     = head_s[2][0];

  assign port1_count = count_s[0];
  assign port2_count = count_s[1];
  assign port3_count = count_s[2];

  assign idle = ~(|nonempty_s);

endmodule

// File: tb/tb_tpm_request_queue.sv
// Directed testbench for tpm_request_queue (DEPTH = 4).
module tb_tpm_request_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        freeze;
  logic        req_valid [3];
  logic        req_wen   [3];
  logic [11:0] req_addr  [3];
  logic [15:0] req_data  [3];
  logic        req_ready [3];
  logic [11:0] addr_o    [3];
  logic [15:0] data_o    [3];
  logic        wen_o     [3];
  logic        valid_o   [3];
  logic [2:0]  count_o   [3];
  logic        idle;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  tpm_request_queue #(.DEPTH(4)) dut (
    .clk(clk), .reset(reset),
    .port1_req_valid(req_valid[0]), .port1_req_ready(req_ready[0]),
    .port1_req_addr(req_addr[0]), .port1_req_data(req_data[0]), .port1_req_wen(req_wen[0]),
    .port2_req_valid(req_valid[1]), .port2_req_ready(req_ready[1]),
    .port2_req_addr(req_addr[1]), .port2_req_data(req_data[1]), .port2_req_wen(req_wen[1]),
    .port3_req_valid(req_valid[2]), .port3_req_ready(req_ready[2]),
    .port3_req_addr(req_addr[2]), .port3_req_data(req_data[2]), .port3_req_wen(req_wen[2]),
    .port1_addr(addr_o[0]), .port1_data_in(data_o[0]), .port1_wen(wen_o[0]), .port1_valid_in(valid_o[0]),
    .port2_addr(addr_o[1]), .port2_data_in(data_o[1]), .port2_wen(wen_o[1]), .port2_valid_in(valid_o[1]),
    .port3_addr(addr_o[2]), .port3_data_in(data_o[2]), .port3_wen(wen_o[2]), .port3_valid_in(valid_o[2]),
    .freeze_inputs(freeze),
    .port1_count(count_o[0]), .port2_count(count_o[1]), .port3_count(count_o[2]),
    .idle(idle)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    for (int p = 0; p < 3; p++) begin
      req_valid[p] = 1'b0;
      req_wen[p]   = 1'b0;
      req_addr[p]  = 12'h000;
      req_data[p]  = 16'h0000;
    end
  endtask

  task automatic test_reset;
    clear_inputs();
    freeze = 1'b0;
    reset  = 1'b1;
    #12;
    for (int p = 0; p < 3; p++) begin
      checks++;
      if (valid_o[p] !== 1'b0 || count_o[p] !== 3'd0 || req_ready[p] !== 1'b1 || addr_o[p] !== 12'h000)
        $display("FAIL reset_state p%0d: valid=%b count=%0d ready=%b addr=%h, expected 0 0 1 000",
                 p, valid_o[p], count_o[p], req_ready[p], addr_o[p]);
      else passes++;
    end
    checks++;
    if (idle !== 1'b1) $display("FAIL reset_idle: got %b expected 1", idle); else passes++;
    tick();
    reset = 1'b0;
    // queue three entries on port 1 with freeze high, then reset mid-stream
    freeze = 1'b1;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_addr[0] = 12'h010 + 12'(i);
      tick();
    end
    req_valid[0] = 1'b0;
    checks++;
    if (count_o[0] !== 3'd3) $display("FAIL reset_prefill_count: got %0d expected 3", count_o[0]); else passes++;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (valid_o[0] !== 1'b0 || count_o[0] !== 3'd0 || req_ready[0] !== 1'b1 || idle !== 1'b1 || addr_o[0] !== 12'h000)
      $display("FAIL reset_async: valid=%b count=%0d ready=%b idle=%b addr=%h, expected 0 0 1 1 000",
               valid_o[0], count_o[0], req_ready[0], idle, addr_o[0]);
    else passes++;
    tick();
    reset  = 1'b0;
    freeze = 1'b0;
    req_valid[0] = 1'b1;
    req_addr[0]  = 12'h777;
    tick();
    req_valid[0] = 1'b0;
    checks++;
    if (valid_o[0] !== 1'b1 || addr_o[0] !== 12'h777 || count_o[0] !== 3'd1)
      $display("FAIL reset_repush: valid=%b addr=%h count=%0d, expected 1 777 1", valid_o[0], addr_o[0], count_o[0]);
    else passes++;
    tick();
    checks++;
    if (valid_o[0] !== 1'b0 || count_o[0] !== 3'd0)
      $display("FAIL reset_repush_pop: valid=%b count=%0d, expected 0 0", valid_o[0], count_o[0]);
    else passes++;
  endtask

  task automatic test_single;
    clear_inputs();
    freeze = 1'b0;
    req_valid[1] = 1'b1;
    req_addr[1]  = 12'h0A5;
    req_data[1]  = 16'h1234;
    req_wen[1]   = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (valid_o[1] !== 1'b1 || addr_o[1] !== 12'h0A5 || data_o[1] !== 16'h1234 || wen_o[1] !== 1'b1 || count_o[1] !== 3'd1)
      $display("FAIL single_present: valid=%b addr=%h data=%h wen=%b count=%0d, expected 1 0a5 1234 1 1",
               valid_o[1], addr_o[1], data_o[1], wen_o[1], count_o[1]);
    else passes++;
    checks++;
    if (idle !== 1'b0) $display("FAIL single_idle: got %b expected 0", idle); else passes++;
    tick();
    checks++;
    if (valid_o[1] !== 1'b0 || addr_o[1] !== 12'h000 || data_o[1] !== 16'h0000 || wen_o[1] !== 1'b0)
      $display("FAIL single_popped: valid=%b addr=%h data=%h wen=%b, expected 0 000 0000 0",
               valid_o[1], addr_o[1], data_o[1], wen_o[1]);
    else passes++;
  endtask

  task automatic test_fill_full;
    clear_inputs();
    freeze = 1'b1;
    req_valid[2] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr[2] = 12'h300 + 12'(i);
      tick();
    end
    req_addr[2] = 12'h304;
    checks++;
    if (req_ready[2] !== 1'b0 || count_o[2] !== 3'd4)
      $display("FAIL full_ready: ready=%b count=%0d, expected 0 4", req_ready[2], count_o[2]);
    else passes++;
    tick();
    req_valid[2] = 1'b0;
    checks++;
    if (count_o[2] !== 3'd4 || addr_o[2] !== 12'h300)
      $display("FAIL full_hold: count=%0d addr=%h, expected 4 300", count_o[2], addr_o[2]);
    else passes++;
    freeze = 1'b0;
    tick();
    checks++;
    if (req_ready[2] !== 1'b1 || count_o[2] !== 3'd3)
      $display("FAIL full_ready_return: ready=%b count=%0d, expected 1 3", req_ready[2], count_o[2]);
    else passes++;
    for (int i = 1; i < 4; i++) begin
      checks++;
      if (addr_o[2] !== 12'h300 + 12'(i))
        $display("FAIL full_drain_order: got %h expected %h", addr_o[2], 12'h300 + 12'(i));
      else passes++;
      tick();
    end
    checks++;
    if (valid_o[2] !== 1'b0 || count_o[2] !== 3'd0)
      $display("FAIL full_drained: valid=%b count=%0d, expected 0 0", valid_o[2], count_o[2]);
    else passes++;
  endtask

  task automatic test_freeze_hold;
    clear_inputs();
    freeze = 1'b1;
    req_valid[0] = 1'b1;
    req_addr[0]  = 12'h100;
    tick();
    req_addr[0]  = 12'h101;
    tick();
    req_valid[0] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (addr_o[0] !== 12'h100 || valid_o[0] !== 1'b1 || count_o[0] !== 3'd2)
        $display("FAIL freeze_hold cycle%0d: addr=%h valid=%b count=%0d, expected 100 1 2",
                 i, addr_o[0], valid_o[0], count_o[0]);
      else passes++;
    end
    freeze = 1'b0;
    tick();
    checks++;
    if (addr_o[0] !== 12'h101 || count_o[0] !== 3'd1)
      $display("FAIL freeze_release: addr=%h count=%0d, expected 101 1", addr_o[0], count_o[0]);
    else passes++;
    tick();
  endtask

  task automatic test_full_push_pop;
    clear_inputs();
    freeze = 1'b1;
    req_valid[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req_addr[0] = 12'h400 + 12'(i);
      tick();
    end
    req_addr[0] = 12'h404;
    freeze = 1'b0;
    tick();
    checks++;
    if (count_o[0] !== 3'd3 || addr_o[0] !== 12'h401 || req_ready[0] !== 1'b1)
      $display("FAIL fullpp_pop_only: count=%0d addr=%h ready=%b, expected 3 401 1", count_o[0], addr_o[0], req_ready[0]);
    else passes++;
    tick();
    req_valid[0] = 1'b0;
    checks++;
    if (count_o[0] !== 3'd3 || addr_o[0] !== 12'h402)
      $display("FAIL fullpp_push_pop: count=%0d addr=%h, expected 3 402", count_o[0], addr_o[0]);
    else passes++;
    tick();
    tick();
    checks++;
    if (addr_o[0] !== 12'h404 || count_o[0] !== 3'd1)
      $display("FAIL fullpp_late_entry: addr=%h count=%0d, expected 404 1", addr_o[0], count_o[0]);
    else passes++;
    tick();
  endtask

  task automatic test_back_to_back;
    clear_inputs();
    freeze = 1'b0;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 6; i++) begin
      req_addr[1] = 12'h500 + 12'(i);
      tick();
      checks++;
      if (count_o[1] !== 3'd1 || addr_o[1] !== 12'h500 + 12'(i))
        $display("FAIL stream cycle%0d: count=%0d addr=%h, expected 1 %h", i, count_o[1], addr_o[1], 12'h500 + 12'(i));
      else passes++;
    end
    req_valid[1] = 1'b0;
    tick();
    checks++;
    if (count_o[1] !== 3'd0 || idle !== 1'b1)
      $display("FAIL stream_end: count=%0d idle=%b, expected 0 1", count_o[1], idle);
    else passes++;
  endtask

  task automatic test_concurrency;
    logic [28:0] model [3][$];
    logic        push;
    logic        pop;
    int          errs;
    errs = 0;
    for (int p = 0; p < 3; p++) model[p].delete();
    for (int cyc = 0; cyc < 2000; cyc++) begin
      freeze = ($urandom_range(3) == 0);
      for (int p = 0; p < 3; p++) begin
        req_valid[p] = ($urandom_range(1) == 1);
        req_addr[p]  = 12'($urandom);
        req_data[p]  = 16'($urandom);
        req_wen[p]   = 1'($urandom);
        if (model[p].size() != 0) begin
          checks++;
          if ({addr_o[p], data_o[p], wen_o[p]} !== model[p][0] || valid_o[p] !== 1'b1) begin
            if (errs < 10) $display("FAIL conc_head p%0d cyc%0d: got %h valid=%b expected %h",
                                    p, cyc, {addr_o[p], data_o[p], wen_o[p]}, valid_o[p], model[p][0]);
            errs++;
          end else passes++;
        end
        push = req_valid[p] && (model[p].size() < 4);
        pop  = (model[p].size() != 0) && !freeze;
        if (pop) void'(model[p].pop_front());
        if (push) model[p].push_back({req_addr[p], req_data[p], req_wen[p]});
      end
      tick();
      for (int p = 0; p < 3; p++) begin
        checks++;
        if (count_o[p] !== 3'(model[p].size())) begin
          if (errs < 10) $display("FAIL conc_count p%0d cyc%0d: got %0d expected %0d", p, cyc, count_o[p], model[p].size());
          errs++;
        end else passes++;
      end
    end
    clear_inputs();
    freeze = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (idle !== 1'b1) $display("FAIL conc_drain_idle: got %b expected 1", idle); else passes++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill_full();
    test_freeze_hold();
    test_full_push_pop();
    test_back_to_back();
    test_concurrency();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/tpm_request_queue.md
# tpm_request_queue

Per-port request buffer sitting directly upstream of the triple-ported memory. It accepts read/write requests from three independent clients over a valid/ready handshake, queues each port's requests in a private FIFO, and presents the FIFO heads to the memory's port inputs. Heads are held stable while the memory asserts `freeze_inputs`, so no request is lost or duplicated during bank-conflict stalls.

## Interface
- `DEPTH`, 4, entries per port FIFO; power of two, ≥2
- `CW`, log2(DEPTH)+1, occupancy counter width (derived, not overridden)

- `clk`  in  1  single clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `portN_req_valid`  in  1  client N request valid (N = 1,2,3)
- `portN_req_ready`  out  1  client N request accepted this edge if valid
- `portN_req_addr`  in  12  client N word address
- `portN_req_data`  in  16  client N write data
- `portN_req_wen`  in  1  client N write enable (1 = write, 0 = read)
- `portN_addr`  out  12  head address to memory port N
- `portN_data_in`  out  16  head write data to memory port N
- `portN_wen`  out  1  head write enable to memory port N
- `portN_valid_in`  out  1  head valid to memory port N
- `freeze_inputs`  in  1  memory stall; head must not advance while high
- `portN_count`  out  CW  current occupancy of FIFO N
- `idle`  out  1  all three FIFOs empty

## Operation
- Three identical, fully independent FIFOs, each with a 29-bit entry {addr, data, wen}, write pointer, read pointer, and occupancy counter.
- Client side:
  - `portN_req_ready = (portN_count != DEPTH)`.
  - On the edge where `req_valid & req_ready`, the entry is written at the write pointer. The write pointer increments mod DEPTH. There is no combinational pass-through.
- Memory side:
  - `portN_valid_in = (portN_count != 0)`.
  - When valid, the payload outputs show the entry at the read pointer.
  - When empty, `portN_addr`, `portN_data_in` and `portN_wen` are forced to 0.
- Pop: on an edge where `portN_valid_in & ~freeze_inputs`, the memory captures the head. The read pointer then increments mod DEPTH.
- Freeze:
  - While `freeze_inputs` is high at an edge, no FIFO pops, and all heads and outputs hold their values.
  - Pushes continue while space remains.
- Counter per edge: +1 on push only, −1 on pop only, unchanged on push and pop together or on neither.
- Pointer wrap-around is a natural modulo-DEPTH wrap. Full and empty are decided by the counter only.
- Simultaneous events:
  - Full with pop: `ready` is 0, so only the pop occurs. `ready` rises the next cycle.
  - Empty with push: only the push occurs, because no valid head exists to pop.
  - Non-empty, non-full with push and pop: both occur and the count is unchanged.
- `idle = (port1_count == 0) & (port2_count == 0) & (port3_count == 0)`.
- Reset, including mid-operation, acts immediately and asynchronously:
  - Pointers and counters go to 0 and queued entries are discarded.
  - Outputs become: `portN_valid_in` = 0, payload outputs = 0, `portN_req_ready` = 1, `portN_count` = 0, `idle` = 1.
  - Storage contents need not be cleared.

## Timing
- Accept-to-present latency is 1 cycle: a request accepted at edge k into an empty FIFO drives `portN_valid_in` = 1 after edge k.
- Per-port throughput is 1 request per cycle when unfrozen. A steady stream through any DEPTH sustains full rate with count ≤ 1.
- `freeze_inputs` is sampled only at rising edges. It may be combinational from the memory and must not feed back into `portN_req_ready` combinationally.
- Request order is preserved per port. There is no ordering relation between ports.
- All outputs are registered or decoded from registered state only. There is no input-to-output combinational path.

## Test plan
- Reset and idle:
  - Stimulus: assert `reset` mid-stream with 3 entries queued on port 1.
  - Required: immediately `port1_valid_in` = 0, `port1_count` = 0, `port1_req_ready` = 1, `idle` = 1. After release, a new push appears after 1 cycle.
- Single request:
  - Stimulus: push {addr 0x0A5, data 0x1234, wen 1} on port 2 at edge k, with freeze low.
  - Required: from edge k through edge k+1, `port2_valid_in` = 1 with that payload. After edge k+1, valid = 0 and payload = 0.
- Fill and full:
  - Stimulus: DEPTH = 4, freeze held high, 5 pushes on port 3.
  - Required: the 5th push sees `ready` = 0 and `port3_count` = 4. Releasing freeze pops one per cycle with addresses in push order. `ready` returns 1 one cycle after the first pop.
- Freeze hold:
  - Stimulus: port 1 head = addr 0x100, then assert freeze for 3 edges.
  - Required: `port1_addr` stays 0x100 and `port1_valid_in` stays 1 for those 3 cycles, and the count is unchanged. After release, the next entry appears after exactly 1 edge.
- Wrap and concurrency:
  - Stimulus: random push/pop/freeze on all 3 ports for 2000 cycles.
  - Required: a scoreboard shows per-port FIFO order with no loss or duplication, and the counts match the model every cycle.
- Simultaneous push/pop at full:
  - Stimulus: port 1 full, with `req_valid` = 1 and freeze low.
  - Required: exactly one pop, no push, `port1_count` = 3 next cycle. The pending request is accepted on the following edge.
